// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver with frame-synchronous loading,
// leading-zero suppression, per-digit blink/blank and anti-ghosting dead time.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int DEAD_CYCLES  = 1,
    parameter int BLINK_FRAMES = 32,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    lz_suppress,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] LIT_TOP = PRE_W'(REFRESH_DIV - 1 - DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_TOP = BLK_W'(BLINK_FRAMES - 1);
    localparam bit               AL      = (ACTIVE_LOW != 0);
    localparam logic [6:0]       SEG_OFF = AL ? 7'h7F : 7'h00;
    localparam logic             DP_OFF  = AL;

    // Slot timer runs down; slot position = REFRESH_DIV-1-pre_cnt.
    logic [PRE_W-1:0]        pre_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_ph;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_v;

    logic                    pre_wrap;
    logic                    boundary;
    logic                    dead;
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic                    upper_zero;
    logic [NUM_DIGITS-1:0]   dark;
    logic [3:0]              cur_nib;
    logic [6:0]              cur_code;
    logic [NUM_DIGITS-1:0]   an_sel;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign pre_wrap = (pre_cnt == '0);
    assign boundary = pre_wrap && (idx == IDX_TOP);
    assign dead     = (pre_cnt > LIT_TOP);

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_dark    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero & (shadow[4*i +: 4] == 4'h0);
            lz_dark[i] = upper_zero;
        end
    end

    assign dark     = blank | (blink_en & {NUM_DIGITS{blink_ph}})
                    | (lz_dark & {NUM_DIGITS{lz_suppress}});
    assign cur_nib  = shadow[4*idx +: 4];
    assign cur_code = hex7(cur_nib);
    assign an_sel   = ~(NUM_DIGITS'(1) << idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt   <= PRE_TOP;
            idx       <= '0;
            blink_cnt <= BLK_TOP;
            blink_ph  <= 1'b0;
            shadow    <= '0;
            pending   <= '0;
            pend_v    <= 1'b0;
        end else begin
            pre_cnt <= pre_wrap ? PRE_TOP : pre_cnt - 1'b1;
            if (pre_wrap)
                idx <= (idx == IDX_TOP) ? '0 : idx + 1'b1;

            if (load)
                pending <= value;
            // A load on the boundary itself bypasses pending and wins.
            if (boundary) begin
                if (load)
                    shadow <= value;
                else if (pend_v)
                    shadow <= pending;
                pend_v <= 1'b0;
            end else if (load) begin
                pend_v <= 1'b1;
            end

            if (boundary) begin
                if (blink_cnt == '0) begin
                    blink_cnt <= BLK_TOP;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_out     <= '1;
            seg_out    <= SEG_OFF;
            dp_out     <= DP_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (dead || dark[idx]) begin
                an_out  <= '1;
                seg_out <= SEG_OFF;
                dp_out  <= DP_OFF;
            end else begin
                an_out  <= an_sel;
                seg_out <= AL ? cur_code : ~cur_code;
                dp_out  <= AL ? ~dp[idx] : dp[idx];
            end
        end
    end
endmodule
